fpu_request_sequencer: RTL and testbench

//  Shares the single FP ALU (MUL/DIV/ADD/SUB, 40-bit BBC BASIC or IEEE-754 format) between two requesters:

---
 rtl/fpu_pkg.sv | 29 ++
 rtl/rr_arbiter2.sv | 14 +
 rtl/fpu_request_sequencer.sv | 129 ++++++++++++
 tb/tb_fpu_request_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types and format-field positions for the FP ALU request sequencer.
// Both the sequencer top and its arbiter import this package.
package fpu_pkg;

    typedef enum logic [1:0] {
        FPU_MUL = 2'b00,
        FPU_DIV,
        FPU_ADD,
        FPU_SUB
    } fpu_func_e;

    localparam int FMT_BIT  = 0;
    localparam int FUNC_LSB = 1;
    localparam int FUNC_MSB = 2;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_RUN,
        SEQ_DONE
    } seq_state_e;

    typedef logic fpu_owner_t;

    // Keep only fmt and func; the reserved bits never reach the ALU.
    function automatic logic [7:0] clean_format(input logic [7:0] f);
        return {5'b0, f[FUNC_MSB:FUNC_LSB], f[FMT_BIT]};
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a lone requester always wins; on a tie the
// port that did not win last time is granted. Output is one-hot or zero.
module rr_arbiter2
    import fpu_pkg::*;
(
    input  logic [1:0] req,
    input  fpu_owner_t last_grant,
    output logic [1:0] grant
);

    assign grant[0] = req[0] & (~req[1] | last_grant);
    assign grant[1] = req[1] & (~req[0] | ~last_grant);

endmodule

// File: rtl/fpu_request_sequencer.sv
// Shares one multi-cycle FP ALU between the Z80 host (port 0) and the GPU
// geometry engine (port 1); one operation in flight, results routed back to the issuer.
module fpu_request_sequencer
    import fpu_pkg::*;
#(
    parameter int SIZE        = 32,
    parameter int ALU_LATENCY = 10
) (
    input  logic            clk,
    input  logic            areset,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [7:0]      req0_format,
    input  logic [SIZE-1:0] req0_a,
    input  logic [SIZE-1:0] req0_b,
    output logic            req0_rvalid,
    output logic [SIZE-1:0] req0_q,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [7:0]      req1_format,
    input  logic [SIZE-1:0] req1_a,
    input  logic [SIZE-1:0] req1_b,
    output logic            req1_rvalid,
    output logic [SIZE-1:0] req1_q,

    output logic            alu_en,
    output logic [7:0]      alu_format,
    output logic [SIZE-1:0] alu_a,
    output logic [SIZE-1:0] alu_b,
    input  logic [SIZE-1:0] alu_q,

    output logic            busy
);

    localparam int CNT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LATENCY - 1);

    if (ALU_LATENCY < 1) begin : g_bad_latency
        $error("fpu_request_sequencer: ALU_LATENCY must be >= 1");
    end

    seq_state_e       state;
    fpu_owner_t       last_grant;
    fpu_owner_t       owner;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       grant;
    logic             accept;

    rr_arbiter2 u_arb (
        .req        ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign req0_ready = (state == SEQ_IDLE) & grant[0];
    assign req1_ready = (state == SEQ_IDLE) & grant[1];
    assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

    // NOTE: every register here is state, so all assignments are non-blocking;
    // blocking ones would let later statements see this cycle's new values.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state       <= SEQ_IDLE;
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            cnt         <= '0;
            alu_en      <= 1'b0;
            alu_format  <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            req0_q      <= '0;
            req1_q      <= '0;
            req0_rvalid <= 1'b0;
            req1_rvalid <= 1'b0;
            busy        <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low each cycle and are raised only in
            // the one state that needs them, so no path leaves them stale.
            alu_en      <= 1'b0;
            req0_rvalid <= 1'b0;
            req1_rvalid <= 1'b0;

            case (state)
                SEQ_IDLE: begin
                    if (accept) begin
                        alu_a      <= grant[1] ? req1_a : req0_a;
                        alu_b      <= grant[1] ? req1_b : req0_b;
                        alu_format <= clean_format(grant[1] ? req1_format : req0_format);
                        owner      <= grant[1];
                        last_grant <= grant[1];
                        cnt        <= CNT_LOAD;
                        alu_en     <= 1'b1;
                        busy       <= 1'b1;
                        state      <= SEQ_RUN;
                    end
                end

                // ALU inputs stay frozen here; its result mux follows format combinationally.
                SEQ_RUN: begin
                    if (cnt == '0) begin
                        if (owner) begin
                            req1_q      <= alu_q;
                            req1_rvalid <= 1'b1;
                        end else begin
                            req0_q      <= alu_q;
                            req0_rvalid <= 1'b1;
                        end
                        state <= SEQ_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                SEQ_DONE: begin
                    busy  <= 1'b0;
                    state <= SEQ_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= SEQ_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_request_sequencer.sv
// Directed bench for fpu_request_sequencer with a table-driven ALU stand-in
// whose result is only valid once the operation has aged ALU_LATENCY cycles.
module tb_fpu_request_sequencer;

    localparam int SIZE = 32;
    localparam int L    = 10;

    logic            clk = 1'b0;
    logic            areset = 1'b1;
    logic            req0_valid = 1'b0, req1_valid = 1'b0;
    logic            req0_ready, req1_ready;
    logic [7:0]      req0_format = '0, req1_format = '0;
    logic [SIZE-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic            req0_rvalid, req1_rvalid;
    logic [SIZE-1:0] req0_q, req1_q;
    logic            alu_en;
    logic [7:0]      alu_format;
    logic [SIZE-1:0] alu_a, alu_b, alu_q;
    logic            busy;

    int n_checks = 0;
    int n_pass   = 0;
    int fmt_bad  = 0;

    fpu_request_sequencer #(.SIZE(SIZE), .ALU_LATENCY(L)) dut (
        .clk         (clk),
        .areset      (areset),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_format (req0_format),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_rvalid (req0_rvalid),
        .req0_q      (req0_q),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_format (req1_format),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_rvalid (req1_rvalid),
        .req1_q      (req1_q),
        .alu_en      (alu_en),
        .alu_format  (alu_format),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_q       (alu_q),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // ALU stand-in: known vectors give their true results, anything else a marker.
    function automatic logic [31:0] alu_model(input logic [7:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f == 8'h01 && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
        if (f == 8'h05 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (f == 8'h03 && a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
        if (f == 8'h07 && a == 32'h3F800000 && b == 32'h3F800000) return 32'h00000000;
        if (f == 8'h00 && a == 32'h82400000 && b == 32'h82000000) return 32'h83400000;
        return 32'hE0E00000 ^ a ^ b;
    endfunction

    logic [7:0] age;
    always @(posedge clk or posedge areset) begin
        if (areset)                          age <= 8'd0;
        else if (alu_en)                     age <= 8'd1;
        else if (age != 0 && age != 8'hFF)   age <= age + 8'd1;
    end

    always_comb begin
        alu_q = 32'hDEADBEEF;
        if (alu_en ? (L - 1 == 0) : (age != 0 && int'(age) >= L - 1))
            alu_q = alu_model(alu_format, alu_a, alu_b);
    end

    always @(negedge clk) if (alu_format[7:3] != 5'b0) fmt_bad++;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic drive(input int p, input logic v, input logic [7:0] f, input logic [31:0] a, input logic [31:0] b);
        if (p == 0) begin
            req0_valid = v; req0_format = f; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_format = f; req1_a = a; req1_b = b;
        end
    endtask

    function automatic logic rdy(input int p);
        return (p == 0) ? req0_ready : req1_ready;
    endfunction

    function automatic logic rv(input int p);
        return (p == 0) ? req0_rvalid : req1_rvalid;
    endfunction

    function automatic logic [31:0] qv(input int p);
        return (p == 0) ? req0_q : req1_q;
    endfunction

    // One op on one port: latency, result, single alu_en, busy, isolation, held inputs and result.
    task automatic do_op(input int p, input logic [7:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expq, input bit scramble, input string name);
        int waitc, lat, en_cnt, busy_bad, other_bad, hold_bad, q_bad;
        logic [31:0] prev_q;
        prev_q = qv(p);
        drive(p, 1'b1, f, a, b);
        #1;
        waitc = 0;
        while (!rdy(p) && waitc < 50) begin
            @(negedge clk); #1; waitc++;
        end
        n_checks++;
        if (!rdy(p)) begin
            $display("FAIL %s_accept: ready=%0b after %0d cycles, required 1", name, rdy(p), waitc);
            drive(p, 1'b0, f, a, b);
            return;
        end else n_pass++;

        lat = 0; en_cnt = 0; busy_bad = 0; other_bad = 0; hold_bad = 0; q_bad = 0;
        do begin
            @(negedge clk); #1; lat++;
            if (scramble) drive(p, 1'b1, 8'hFF, $urandom, $urandom);
            else if (lat == 1) drive(p, 1'b0, f, a, b);
            if (alu_en) en_cnt++;
            if (!busy) busy_bad++;
            if (rv(1 - p) || req0_ready || req1_ready) other_bad++;
            if (!rv(p) && (alu_format !== {5'b0, f[2:0]} || alu_a !== a || alu_b !== b)) hold_bad++;
            if (!rv(p) && qv(p) !== prev_q) q_bad++;
        end while (!rv(p) && lat < L + 20);
        drive(p, 1'b0, f, a, b);

        n_checks++;
        if (lat !== L + 1) $display("FAIL %s_latency: got %0d cycles, required %0d", name, lat, L + 1);
        else n_pass++;
        n_checks++;
        if (qv(p) !== expq) $display("FAIL %s_q: got %h, required %h", name, qv(p), expq);
        else n_pass++;
        n_checks++;
        if (en_cnt !== 1) $display("FAIL %s_alu_en: got %0d pulses, required 1", name, en_cnt);
        else n_pass++;
        n_checks++;
        if (busy_bad !== 0) $display("FAIL %s_busy: low in %0d op cycles, required 0", name, busy_bad);
        else n_pass++;
        n_checks++;
        if (other_bad !== 0) $display("FAIL %s_isolation: %0d cycles with other rvalid or ready high, required 0", name, other_bad);
        else n_pass++;
        n_checks++;
        if (hold_bad !== 0) $display("FAIL %s_hold: ALU inputs wrong in %0d cycles, required 0", name, hold_bad);
        else n_pass++;
        n_checks++;
        if (q_bad !== 0) $display("FAIL %s_q_held: result changed early in %0d cycles, required 0", name, q_bad);
        else n_pass++;
    endtask

    task automatic pulse_reset;
        @(negedge clk);
        areset = 1'b1;
        repeat (2) @(negedge clk);
        areset = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        #1;
        n_checks++;
        if ({req0_rvalid, req1_rvalid, alu_en, busy, req0_ready, req1_ready} !== 6'b0 ||
            req0_q !== '0 || req1_q !== '0 || alu_a !== '0 || alu_b !== '0 || alu_format !== '0)
            $display("FAIL reset_outputs: got q0=%h q1=%h a=%h fmt=%h busy=%b, required all 0",
                     req0_q, req1_q, alu_a, alu_format, busy);
        else n_pass++;
        repeat (2) @(negedge clk);
        areset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0)
            $display("FAIL idle_after_reset: got busy=%b rdy0=%b rdy1=%b, required 0 0 0", busy, req0_ready, req1_ready);
        else n_pass++;
    endtask

    task automatic test_port0_mul;
        do_op(0, 8'h01, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, "t1_p0_mul");
    endtask

    task automatic test_port1_add;
        do_op(1, 8'h05, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, "t2_p1_add");
    endtask

    task automatic test_round_robin;
        int acc_port[4];
        int acc_cyc[4];
        int n_acc, n_rv, both_bad, r_bad, cyc;
        pulse_reset();
        drive(0, 1'b1, 8'h01, 32'h40000000, 32'h40400000);
        drive(1, 1'b1, 8'h05, 32'h3F800000, 32'h40000000);
        #1;
        n_acc = 0; n_rv = 0; both_bad = 0; r_bad = 0; cyc = 0;
        while (n_rv < 4 && cyc < 4 * (L + 2) + 30) begin
            if (req0_ready && req1_ready) both_bad++;
            if (n_acc < 4 && req0_valid && req0_ready) begin acc_port[n_acc] = 0; acc_cyc[n_acc] = cyc; n_acc++; end
            if (n_acc < 4 && req1_valid && req1_ready) begin acc_port[n_acc] = 1; acc_cyc[n_acc] = cyc; n_acc++; end
            if (req0_rvalid) begin n_rv++; if (req0_q !== 32'h40C00000) r_bad++; end
            if (req1_rvalid) begin n_rv++; if (req1_q !== 32'h40400000) r_bad++; end
            @(negedge clk); #1; cyc++;
        end
        drive(0, 1'b0, 8'h00, '0, '0);
        drive(1, 1'b0, 8'h00, '0, '0);

        n_checks++;
        if (n_acc !== 4 || n_rv !== 4) $display("FAIL t3_count: got %0d accepts %0d results, required 4 4", n_acc, n_rv);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= n_acc || acc_port[i] !== (i % 2))
                $display("FAIL t3_grant%0d: got port %0d, required %0d", i, (i < n_acc) ? acc_port[i] : -1, i % 2);
            else n_pass++;
        end
        for (int i = 1; i < 4; i++) begin
            n_checks++;
            if (i >= n_acc || acc_cyc[i] - acc_cyc[i-1] !== L + 2)
                $display("FAIL t3_spacing%0d: got %0d cycles, required %0d", i, (i < n_acc) ? acc_cyc[i] - acc_cyc[i-1] : -1, L + 2);
            else n_pass++;
        end
        n_checks++;
        if (both_bad !== 0 || r_bad !== 0)
            $display("FAIL t3_ready_results: got %0d dual-ready, %0d bad results, required 0 0", both_bad, r_bad);
        else n_pass++;
        @(negedge clk); #1;
    endtask

    task automatic test_input_change;
        do_op(0, 8'hF9, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b1, "t4_scramble");
        n_checks++;
        if (fmt_bad !== 0) $display("FAIL t4_fmt_reserved: nonzero alu_format[7:3] in %0d cycles, required 0", fmt_bad);
        else n_pass++;
    endtask

    task automatic test_reset_mid_op;
        int waitc, rv_bad;
        drive(0, 1'b1, 8'h01, 32'h40000000, 32'h40400000);
        #1;
        waitc = 0;
        while (!req0_ready && waitc < 50) begin @(negedge clk); #1; waitc++; end
        repeat (3) @(negedge clk);
        areset = 1'b1;
        drive(0, 1'b0, 8'h01, 32'h40000000, 32'h40400000);
        #1;
        n_checks++;
        if (busy !== 1'b0 || alu_en !== 1'b0 || req0_rvalid !== 1'b0 || req0_q !== '0 || req1_q !== '0 ||
            alu_a !== '0 || alu_b !== '0 || alu_format !== '0)
            $display("FAIL t5_reset_clear: got busy=%b q0=%h q1=%h a=%h fmt=%h, required all 0",
                     busy, req0_q, req1_q, alu_a, alu_format);
        else n_pass++;
        rv_bad = 0;
        repeat (2) begin @(negedge clk); if (req0_rvalid || req1_rvalid || busy) rv_bad++; end
        areset = 1'b0;
        repeat (L + 5) begin @(negedge clk); #1; if (req0_rvalid || req1_rvalid || busy) rv_bad++; end
        n_checks++;
        if (rv_bad !== 0) $display("FAIL t5_no_rvalid: got %0d cycles with rvalid or busy, required 0", rv_bad);
        else n_pass++;
        do_op(0, 8'h01, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, "t5_represent");
    endtask

    task automatic test_back_to_back;
        do_op(0, 8'h03, 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, "t6_div");
        do_op(0, 8'h07, 32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0, "t6_sub");
        do_op(0, 8'h00, 32'h82400000, 32'h82000000, 32'h83400000, 1'b0, "t6_bbc_mul");
        n_checks++;
        if (req1_q !== '0) $display("FAIL t6_p1_untouched: got %h, required 00000000", req1_q);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_port0_mul();
        test_port1_add();
        test_round_robin();
        test_input_change();
        test_reset_mid_op();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
